// File: rtl/seg_scan4.sv
// Four-digit multiplexed 7-segment scanner with a once-per-frame letter snapshot.
// Optional anti-ghosting blanking at the start of each slot when SEG_SCAN4_BLANK_EN is defined.
module seg_scan4 #(
    parameter int DIV   = 50000,
    parameter int BLANK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [27:0] seg_in,
    output logic [3:0]  an,
    output logic [6:0]  seg_out,
    output logic        frame_tick
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    if (DIV < 2 || DIV > 1048576) begin : g_div_range
        $error("seg_scan4: DIV must lie in 2..2^20");
    end
    if (BLANK < 0 || BLANK >= DIV) begin : g_blank_range
        $error("seg_scan4: BLANK must lie in 0..DIV-1");
    end

    typedef enum logic [1:0] {D0, D1, D2, D3} dig_t;

    dig_t             dig_p0, dig_nxt;
    logic [CNT_W-1:0] cnt_p0, cnt_nxt;
    logic [27:0]      frame_p0;
    logic             slot_end;
    logic             frame_end;
    logic             blank;
    logic [3:0]       an_nxt;
    logic [6:0]       seg_nxt;

`ifdef SEG_SCAN4_BLANK_EN
    localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK);
    assign blank = (cnt_p0 < BLANK_C);
`else
    assign blank = 1'b0;
`endif

    // Stage p0: slot counter, digit state and frame snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_p0   <= D0;
            cnt_p0   <= '0;
            frame_p0 <= '0;
        end else begin
            dig_p0 <= dig_nxt;
            cnt_p0 <= cnt_nxt;
            if (frame_end) begin
                frame_p0 <= seg_in;
            end
        end
    end

    always_comb begin
        slot_end  = (cnt_p0 == CNT_LAST);
        frame_end = slot_end && (dig_p0 == D3);
        cnt_nxt   = slot_end ? '0 : cnt_p0 + 1'b1;
        dig_nxt   = dig_p0;
        an_nxt    = 4'b1111;
        seg_nxt   = 7'h7f;

        if (slot_end) begin
            case (dig_p0)
                D0:      dig_nxt = D1;
                D1:      dig_nxt = D2;
                D2:      dig_nxt = D3;
                default: dig_nxt = D0;
            endcase
        end

        case (dig_p0)
            D0: begin
                an_nxt  = 4'b1110;
                seg_nxt = ~frame_p0[6:0];
            end
            D1: begin
                an_nxt  = 4'b1101;
                seg_nxt = ~frame_p0[13:7];
            end
            D2: begin
                an_nxt  = 4'b1011;
                seg_nxt = ~frame_p0[20:14];
            end
            default: begin
                an_nxt  = 4'b0111;
                seg_nxt = ~frame_p0[27:21];
            end
        endcase

        if (blank) begin
            an_nxt  = 4'b1111;
            seg_nxt = 7'h7f;
        end
    end

    // Stage p1: registered display outputs, one cycle behind the scan state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= 4'b1111;
            seg_out    <= 7'h7f;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_nxt;
            seg_out    <= seg_nxt;
            frame_tick <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg_scan4.sv
// Directed bench for seg_scan4 with DIV=4, BLANK=1; expectations follow SEG_SCAN4_BLANK_EN.
module tb_seg_scan4;

    localparam int DIV   = 4;
    localparam int BLANK = 1;
`ifdef SEG_SCAN4_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [27:0] seg_in;
    logic [3:0]  an;
    logic [6:0]  seg_out;
    logic        frame_tick;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    logic [3:0] an_tab  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] map_tab [4] = '{7'h77, 7'h7b, 7'h7d, 7'h7e};
    logic [6:0] new_tab [4] = '{7'h40, 7'h79, 7'h24, 7'h30};

    localparam logic [27:0] MAP_PAT = {7'h01, 7'h02, 7'h04, 7'h08};
    localparam logic [27:0] NEW_PAT = {7'h4f, 7'h5b, 7'h06, 7'h3f};

    seg_scan4 #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .an         (an),
        .seg_out    (seg_out),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset(input logic [27:0] v);
        seg_in = v;
        rst_n  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        seg_in = 28'hfffffff;
        rst_n  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            nchk++;
            if (an !== 4'hf) begin
                nerr++;
                $display("FAIL reset_an cyc=%0d got=%b want=1111", i, an);
            end
            nchk++;
            if (seg_out !== 7'h7f) begin
                nerr++;
                $display("FAIL reset_seg cyc=%0d got=%h want=7f", i, seg_out);
            end
            nchk++;
            if (frame_tick !== 1'b0) begin
                nerr++;
                $display("FAIL reset_tick cyc=%0d got=%b want=0", i, frame_tick);
            end
        end
    endtask

    task automatic test_scan_order();
        int d;
        logic bl;
        logic [3:0] ean;
        apply_reset(28'h0000000);
        for (int k = 1; k <= 32; k++) begin
            step();
            d   = ((cyc - 1) / DIV) % 4;
            bl  = BLANK_ON && (((cyc - 1) % DIV) < BLANK);
            ean = bl ? 4'hf : an_tab[d];
            nchk++;
            if (an !== ean) begin
                nerr++;
                $display("FAIL scan_an cyc=%0d got=%b want=%b", cyc, an, ean);
            end
            nchk++;
            if ($countones(~an) > 1) begin
                nerr++;
                $display("FAIL scan_onehot cyc=%0d got=%b want=at_most_one_low", cyc, an);
            end
            nchk++;
            if (seg_out !== 7'h7f) begin
                nerr++;
                $display("FAIL scan_seg cyc=%0d got=%h want=7f", cyc, seg_out);
            end
            nchk++;
            if (frame_tick !== (cyc == 16 || cyc == 32)) begin
                nerr++;
                $display("FAIL scan_tick cyc=%0d got=%b want=%b", cyc, frame_tick, (cyc == 16 || cyc == 32));
            end
        end
    endtask

    task automatic test_data_map();
        int d;
        logic bl;
        logic [3:0] ean;
        logic [6:0] eseg;
        apply_reset(MAP_PAT);
        for (int k = 1; k <= 32; k++) begin
            step();
            d    = ((cyc - 1) / DIV) % 4;
            bl   = BLANK_ON && (((cyc - 1) % DIV) < BLANK);
            ean  = bl ? 4'hf : an_tab[d];
            eseg = (bl || cyc <= 16) ? 7'h7f : map_tab[d];
            nchk++;
            if (an !== ean) begin
                nerr++;
                $display("FAIL map_an cyc=%0d got=%b want=%b", cyc, an, ean);
            end
            nchk++;
            if (seg_out !== eseg) begin
                nerr++;
                $display("FAIL map_seg cyc=%0d got=%h want=%h", cyc, seg_out, eseg);
            end
            nchk++;
            if (frame_tick !== (cyc == 16 || cyc == 32)) begin
                nerr++;
                $display("FAIL map_tick cyc=%0d got=%b want=%b", cyc, frame_tick, (cyc == 16 || cyc == 32));
            end
        end
    endtask

    // Continues from test_data_map without reset: frame 3 holds MAP_PAT.
    task automatic test_no_tear();
        int d;
        logic bl;
        logic [3:0] ean;
        logic [6:0] eseg;
        for (int k = 33; k <= 64; k++) begin
            step();
            d    = ((cyc - 1) / DIV) % 4;
            bl   = BLANK_ON && (((cyc - 1) % DIV) < BLANK);
            ean  = bl ? 4'hf : an_tab[d];
            eseg = bl ? 7'h7f : (cyc <= 48 ? map_tab[d] : new_tab[d]);
            nchk++;
            if (an !== ean) begin
                nerr++;
                $display("FAIL tear_an cyc=%0d got=%b want=%b", cyc, an, ean);
            end
            nchk++;
            if (seg_out !== eseg) begin
                nerr++;
                $display("FAIL tear_seg cyc=%0d got=%h want=%h", cyc, seg_out, eseg);
            end
            nchk++;
            if (frame_tick !== (cyc == 48 || cyc == 64)) begin
                nerr++;
                $display("FAIL tear_tick cyc=%0d got=%b want=%b", cyc, frame_tick, (cyc == 48 || cyc == 64));
            end
            if (cyc == 38) seg_in = NEW_PAT;
        end
    endtask

    task automatic test_async_reset();
        int d;
        logic bl;
        logic [3:0] ean;
        apply_reset(MAP_PAT);
        for (int k = 1; k <= 26; k++) step();
        nchk++;
        if (an !== 4'b1011) begin
            nerr++;
            $display("FAIL arst_pre_an cyc=%0d got=%b want=1011", cyc, an);
        end
        #2;
        rst_n = 1'b0;
        #1;
        nchk++;
        if (an !== 4'hf) begin
            nerr++;
            $display("FAIL arst_an got=%b want=1111", an);
        end
        nchk++;
        if (seg_out !== 7'h7f) begin
            nerr++;
            $display("FAIL arst_seg got=%h want=7f", seg_out);
        end
        nchk++;
        if (frame_tick !== 1'b0) begin
            nerr++;
            $display("FAIL arst_tick got=%b want=0", frame_tick);
        end
        step();
        rst_n = 1'b1;
        cyc   = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            d   = ((cyc - 1) / DIV) % 4;
            bl  = BLANK_ON && (((cyc - 1) % DIV) < BLANK);
            ean = bl ? 4'hf : an_tab[d];
            nchk++;
            if (an !== ean) begin
                nerr++;
                $display("FAIL arst_resume_an cyc=%0d got=%b want=%b", cyc, an, ean);
            end
            nchk++;
            if (seg_out !== 7'h7f) begin
                nerr++;
                $display("FAIL arst_resume_seg cyc=%0d got=%h want=7f", cyc, seg_out);
            end
            nchk++;
            if (frame_tick !== (cyc == 16)) begin
                nerr++;
                $display("FAIL arst_resume_tick cyc=%0d got=%b want=%b", cyc, frame_tick, (cyc == 16));
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        seg_in = 28'h0;
        test_reset();
        test_scan_order();
        test_data_map();
        test_no_tear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
